// File: rtl/seq_stream_pkg.sv
// seq_stream_pkg: shared state type, default word width and index-width helper
package seq_stream_pkg;
  typedef enum logic {IDLE, SHIFT} state_e;
  localparam int DEFAULT_WIDTH = 32;
  function automatic int idx_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction
endpackage

// File: rtl/word_hold_buffer.sv
// word_hold_buffer: single-entry word register with full flag
//   clk, reset        : clock, asynchronous active-high reset
//   wr_i / data_i     : write strobe and word to store
//   rd_i              : read strobe, frees the entry
//   full_o / data_o   : entry occupied, stored word
// A same-edge read and write leaves the entry full with the new word.
module word_hold_buffer
  import seq_stream_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             rd_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
);
  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  always_comb begin
    full_d = wr_i ? 1'b1 : (rd_i ? 1'b0 : full_q);
    data_d = wr_i ? data_i : data_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end
  assign full_o = full_q;
  assign data_o = data_q;
endmodule

// File: rtl/sequence_stream_source.sv
// sequence_stream_source: serialises parallel words onto a gapless bit stream
//   clk, reset                         : clock, asynchronous active-high reset
//   load_valid/load_data/load_ready    : parallel word input handshake
//   bit_ready/bit_out/bit_valid/last   : serial bit output handshake, last marks final bit
//   busy                               : word in shifter or holding buffer
module sequence_stream_source
  import seq_stream_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             bit_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             last,
  output logic             busy
);
  localparam int IW = idx_width(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, buf_data;
  logic [IW-1:0]    idx_q, idx_d;
  logic             buf_full, load_xfer, bit_xfer, end_word, buf_wr, buf_rd;
  assign load_ready = !buf_full;
  assign bit_valid  = (state_q == SHIFT);
  assign bit_out    = (MSB_FIRST != 0) ? sr_q[WIDTH-1] : sr_q[0];
  assign last       = bit_valid && (idx_q == LAST_IDX);
  assign busy       = bit_valid || buf_full;
  assign load_xfer  = load_valid && load_ready;
  assign bit_xfer   = bit_valid && bit_ready;
  assign end_word   = bit_xfer && (idx_q == LAST_IDX);
  // With an empty buffer, a load arriving on the end-of-word edge bypasses it
  assign buf_wr     = load_xfer && bit_valid && !(end_word && !buf_full);
  assign buf_rd     = end_word && buf_full;
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    if (state_q == IDLE) begin
      if (load_xfer) begin
        sr_d    = load_data;
        idx_d   = '0;
        state_d = SHIFT;
      end
    end else if (bit_xfer) begin
      if (idx_q != LAST_IDX) begin
        sr_d  = (MSB_FIRST != 0) ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
        idx_d = idx_q + 1'b1;
      end else if (buf_full) begin
        sr_d  = buf_data;
        idx_d = '0;
      end else if (load_xfer) begin
        sr_d  = load_data;
        idx_d = '0;
      end else begin
        state_d = IDLE;
      end
    end
  end
  word_hold_buffer #(.WIDTH(WIDTH)) u_buf (
    .clk    (clk),
    .reset  (reset),
    .wr_i   (buf_wr),
    .data_i (load_data),
    .rd_i   (buf_rd),
    .full_o (buf_full),
    .data_o (buf_data)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
    end
  end
endmodule

// File: tb/tb_sequence_stream_source.sv
// tb_sequence_stream_source: scoreboard bench for the serialiser (32-bit MSB-first and 8-bit LSB-first)
module tb_sequence_stream_source;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        lv = 1'b0, br = 1'b1;
  logic [31:0] ld = '0;
  logic        lr, bo, bv, la, bs;
  logic        lv8 = 1'b0, br8 = 1'b1;
  logic [7:0]  ld8 = '0;
  logic        lr8, bo8, bv8, la8, bs8;
  int          vecs = 0, errs = 0;
  typedef struct packed {logic b; logic l;} sb_t;
  sb_t q[$];

  always #5 clk = ~clk;

  sequence_stream_source #(.WIDTH(32), .MSB_FIRST(1)) dut32 (
    .clk(clk), .reset(reset), .load_valid(lv), .load_data(ld), .load_ready(lr),
    .bit_ready(br), .bit_out(bo), .bit_valid(bv), .last(la), .busy(bs)
  );
  sequence_stream_source #(.WIDTH(8), .MSB_FIRST(0)) dut8 (
    .clk(clk), .reset(reset), .load_valid(lv8), .load_data(ld8), .load_ready(lr8),
    .bit_ready(br8), .bit_out(bo8), .bit_valid(bv8), .last(la8), .busy(bs8)
  );

  // Scoreboard: accepted words push their bits MSB-first, bit transfers pop and compare
  always @(negedge clk) begin
    sb_t e;
    if (reset) q.delete();
    else begin
      if (bv && br) begin
        vecs++;
        if (q.size() == 0) begin
          errs++;
          $display("FAIL spurious_bit: bit_valid=1 bit_out=%0b with nothing expected", bo);
        end else begin
          e = q.pop_front();
          if (bo !== e.b || la !== e.l) begin
            errs++;
            $display("FAIL stream_bit: got bit=%0b last=%0b, want bit=%0b last=%0b", bo, la, e.b, e.l);
          end
        end
      end
      if (lv && lr)
        for (int i = 0; i < 32; i++) begin
          e.b = ld[31-i];
          e.l = (i == 31);
          q.push_back(e);
        end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int lim);
    for (int i = 0; i < lim && (bv === 1'b1 || q.size() != 0); i++) tick();
  endtask

  task automatic test_reset;
    lv = 1'b1; ld = 32'hDEADBEEF; lv8 = 1'b1; ld8 = 8'hA5;
    #1 reset = 1'b1;
    #1;
    vecs++;
    if ({bv, bo, la, bs, lr} !== 5'b00001) begin
      errs++; $display("FAIL reset32: got v/o/l/b/r=%b want 00001", {bv, bo, la, bs, lr});
    end
    vecs++;
    if ({bv8, bo8, la8, bs8, lr8} !== 5'b00001) begin
      errs++; $display("FAIL reset8: got v/o/l/b/r=%b want 00001", {bv8, bo8, la8, bs8, lr8});
    end
    tick(); tick();
    vecs++;
    if ({bv, bs, bv8, bs8} !== 4'b0000) begin
      errs++; $display("FAIL load_in_reset: got v/b/v8/b8=%b want 0000", {bv, bs, bv8, bs8});
    end
    lv = 1'b0; lv8 = 1'b0;
    #2 reset = 1'b0;
    tick();
    vecs++;
    if ({bv, bs, lr} !== 3'b001) begin
      errs++; $display("FAIL post_reset: got v/b/r=%b want 001", {bv, bs, lr});
    end
  endtask

  task automatic test_single;
    int n = 0;
    br = 1'b1; lv = 1'b1; ld = 32'h2B5C5656;
    vecs++;
    if (bv !== 1'b0) begin errs++; $display("FAIL pre_load_valid: got %0b want 0", bv); end
    tick();
    lv = 1'b0;
    vecs++;
    if (bv !== 1'b1) begin errs++; $display("FAIL load_latency: bit_valid got %0b want 1", bv); end
    while (bv === 1'b1 && n < 40) begin n++; tick(); end
    vecs++;
    if (n != 32) begin errs++; $display("FAIL single_count: got %0d bits want 32", n); end
    vecs++;
    if ({bv, bs, lr} !== 3'b001) begin
      errs++; $display("FAIL single_end: got v/b/r=%b want 001", {bv, bs, lr});
    end
  endtask

  task automatic test_back_to_back;
    int n = 0, fr = 0;
    lv = 1'b1; ld = 32'h2B5C5656;
    tick();
    ld = 32'hFFFF0000;
    while (bv === 1'b1 && n < 80) begin
      n++;
      if (n == 2) begin
        lv = 1'b0;
        vecs++;
        if ({lr, bs} !== 2'b01) begin
          errs++; $display("FAIL buf_full_ready: got ready/busy=%b want 01", {lr, bs});
        end
      end
      if (n > 2 && lr === 1'b1 && fr == 0) fr = n;
      tick();
    end
    vecs++;
    if (n != 64) begin errs++; $display("FAIL b2b_count: got %0d contiguous bits want 64", n); end
    vecs++;
    if (fr != 33) begin errs++; $display("FAIL b2b_ready_return: got bit %0d want 33", fr); end
  endtask

  task automatic test_direct;
    int t = 0;
    lv = 1'b1; ld = 32'h12345678;
    tick();
    lv = 1'b0;
    while (la !== 1'b1 && t < 50) begin t++; tick(); end
    vecs++;
    if ({la, lr, dut32.buf_full} !== 3'b110) begin
      errs++; $display("FAIL direct_setup: got last/ready/full=%b want 110", {la, lr, dut32.buf_full});
    end
    lv = 1'b1; ld = 32'h80000001;
    tick();
    lv = 1'b0;
    vecs++;
    if ({bo, bv, dut32.buf_full} !== 3'b110 || dut32.idx_q !== 5'd0) begin
      errs++;
      $display("FAIL direct_reload: got out/valid/full=%b idx=%0d want 110 idx=0",
               {bo, bv, dut32.buf_full}, dut32.idx_q);
    end
    drain(100);
    vecs++;
    if ({bv, bs} !== 2'b00) begin errs++; $display("FAIL direct_drain: got v/b=%b want 00", {bv, bs}); end
  endtask

  task automatic test_backpressure;
    logic [3:0] pat;
    logic       pb, pbo;
    int         cnt = 0;
    pat = 4'b1001;
    lv = 1'b1; ld = 32'hA5C30F96;
    tick();
    lv = 1'b0;
    for (int k = 0; k < 200 && bv === 1'b1; k++) begin
      br = pat[k%4];
      if (br) cnt++;
      pb = br; pbo = bo;
      tick();
      if (!pb && bv === 1'b1) begin
        vecs++;
        if (bo !== pbo) begin errs++; $display("FAIL bp_hold: got %0b want %0b", bo, pbo); end
      end
    end
    br = 1'b1;
    vecs++;
    if (cnt != 32 || bv !== 1'b0) begin
      errs++; $display("FAIL bp_count: got %0d transfers valid=%0b want 32 valid=0", cnt, bv);
    end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    br = 1'b1; lv = 1'b1; ld = 32'h2B5C5656;
    tick();
    ld = 32'hFFFF0000;
    tick();
    lv = 1'b0;
    repeat (9) tick();
    vecs++;
    if ({bv, bs, lr} !== 3'b110) begin
      errs++; $display("FAIL mid_setup: got v/b/r=%b want 110", {bv, bs, lr});
    end
    #2 reset = 1'b1;
    #1;
    vecs++;
    if ({bv, bs, lr, la} !== 4'b0010) begin
      errs++; $display("FAIL async_reset: got v/b/r/l=%b want 0010", {bv, bs, lr, la});
    end
    tick(); tick();
    #2 reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bv === 1'b1) n++;
    end
    vecs++;
    if (n != 0 || bs !== 1'b0) begin
      errs++; $display("FAIL residual_bits: got %0d bits busy=%0b want 0 bits busy=0", n, bs);
    end
  endtask

  task automatic test_lsb;
    logic [7:0] w;
    w = 8'b0000_0110;
    br8 = 1'b1; lv8 = 1'b1; ld8 = w;
    tick();
    lv8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vecs++;
      if ({bv8, bo8, la8} !== {1'b1, w[i], (i == 7)}) begin
        errs++;
        $display("FAIL lsb_bit%0d: got v/o/l=%b want %b", i, {bv8, bo8, la8}, {1'b1, w[i], (i == 7)});
      end
      tick();
    end
    vecs++;
    if ({bv8, bs8} !== 2'b00) begin errs++; $display("FAIL lsb_end: got v/b=%b want 00", {bv8, bs8}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_direct();
    test_backpressure();
    test_reset_mid();
    test_lsb();
    vecs++;
    if (q.size() != 0) begin errs++; $display("FAIL leftover: got %0d unsent bits want 0", q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
